// File: rtl/axi_packet_len_check.sv
// Packet length checker: compares the word count in each header against the
// words actually received. Good packets pass through unchanged; short or long
// packets get o_terror on their final word, and long ones are cut at the
// expected length with the excess discarded.
module axi_packet_len_check #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 6,
  parameter int LEN_LSB   = 0,
  parameter int LEN_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  input  logic             i_tlast,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  output logic             o_tlast,
  output logic             o_terror,
  input  logic             o_tready,
  output logic [15:0]      err_cnt
);

  localparam logic [1:0] S_HDR  = 2'd0;
  localparam logic [1:0] S_BODY = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam int MAX = 2**SIZE;
  // Comparison width wide enough for both the raw field and MAX.
  localparam int LW = (LEN_WIDTH > SIZE + 1) ? LEN_WIDTH : SIZE + 1;
  localparam logic [SIZE:0] MAXC = {1'b1, {SIZE{1'b0}}};
  localparam logic [SIZE:0] ONE  = {{SIZE{1'b0}}, 1'b1};

  logic [1:0]     state, nx_state;
  logic [SIZE:0]  cnt, exp_r, exp_w, n;
  logic           bad_r, hdr_bad;
  logic [LW-1:0]  len_x;
  logic           acc, ld, nx_last, nx_err;

  // Header decode: zero or oversize lengths fall back to the maximum so the
  // downstream buffer is never overrun.
  assign len_x   = LW'(i_tdata[LEN_LSB +: LEN_WIDTH]);
  assign hdr_bad = (len_x == '0) || (len_x > LW'(MAX));
  assign exp_w   = hdr_bad ? MAXC : len_x[SIZE:0];
  assign n       = cnt + ONE;

  // DROP discards independently of the output register.
  assign i_tready = (state == S_DROP) | ~o_tvalid | o_tready;
  assign acc      = i_tvalid & i_tready;

  // Next-state and output-word decision for an accepted input word.
  always_comb begin
    ld       = 1'b0;
    nx_last  = 1'b0;
    nx_err   = 1'b0;
    nx_state = state;
    case (state)
      S_HDR: if (acc) begin
        ld = 1'b1;
        if (i_tlast) begin
          nx_last = 1'b1;
          nx_err  = hdr_bad | (exp_w != ONE);
        end else if (exp_w == ONE) begin
          nx_last  = 1'b1;
          nx_err   = 1'b1;
          nx_state = S_DROP;
        end else begin
          nx_state = S_BODY;
        end
      end
      S_BODY: if (acc) begin
        ld = 1'b1;
        if (i_tlast) begin
          nx_last  = 1'b1;
          nx_err   = bad_r | (n != exp_r);
          nx_state = S_HDR;
        end else if (n == exp_r) begin
          nx_last  = 1'b1;
          nx_err   = 1'b1;
          nx_state = S_DROP;
        end
      end
      S_DROP: if (acc && i_tlast) nx_state = S_HDR;
      default: nx_state = S_HDR;
    endcase
  end

  // Packet state, word counter and the single output register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_HDR;
      cnt      <= '0;
      exp_r    <= '0;
      bad_r    <= 1'b0;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_terror <= 1'b0;
      o_tdata  <= '0;
    end else if (clear) begin
      state    <= S_HDR;
      cnt      <= '0;
      exp_r    <= '0;
      bad_r    <= 1'b0;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_terror <= 1'b0;
      o_tdata  <= '0;
    end else begin
      state <= nx_state;
      if (acc && state == S_HDR) begin
        exp_r <= exp_w;
        bad_r <= hdr_bad;
        cnt   <= ONE;
      end else if (acc && state == S_BODY) begin
        cnt <= n;
      end
      if (ld) begin
        o_tvalid <= 1'b1;
        o_tdata  <= i_tdata;
        o_tlast  <= nx_last;
        o_terror <= nx_err;
      end else if (o_tready) begin
        o_tvalid <= 1'b0;
      end
    end
  end

  // Saturating count of errored packets, one per errored final word loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_cnt <= '0;
    else if (clear)
      err_cnt <= '0;
    else if (ld && nx_last && nx_err && err_cnt != 16'hFFFF)
      err_cnt <= err_cnt + 16'd1;
  end

endmodule

// File: tb/tb_axi_packet_len_check.sv
// Directed bench for axi_packet_len_check: packet-level expected streams,
// output hold/ready rules, reset/clear behaviour and counter saturation.
module tb_axi_packet_len_check;
  localparam int MAXW = 64;

  logic        clk = 1'b0, reset = 1'b1, clear = 1'b0;
  logic [31:0] i_tdata = '0;
  logic        i_tvalid = 1'b0, i_tlast = 1'b0;
  wire         i_tready;
  wire  [31:0] o_tdata;
  wire         o_tvalid, o_tlast, o_terror;
  wire         o_tready;
  wire  [15:0] err_cnt;

  logic bp_rand = 1'b0, ordy_force = 1'b1, rnd_bit = 1'b1;
  logic mon_en = 1'b0, rec = 1'b1, lat_chk = 1'b0;
  int   checks = 0, failures = 0, stalls = 0;
  logic [33:0] rx_q[$], ex_q[$];

  assign o_tready = bp_rand ? rnd_bit : ordy_force;

  axi_packet_len_check #(.WIDTH(32), .SIZE(6), .LEN_LSB(0), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tlast(i_tlast), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .o_terror(o_terror),
    .o_tready(o_tready), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Snapshot just before each rising edge: records handshakes, checks holds.
  logic [33:0] prev = '0;
  logic        prev_stall = 1'b0;
  always begin
    @(negedge clk); #2;
    if (mon_en) begin
      if (prev_stall) chk("hold", 64'({o_tvalid, o_tlast, o_terror, o_tdata}), 64'({1'b1, prev}));
      if (!i_tready) chk("irdy_rule", 64'(o_tvalid & ~o_tready), 64'd1);
      if (o_tvalid && o_tready && rec) rx_q.push_back({o_tlast, o_terror, o_tdata});
      prev_stall = o_tvalid & ~o_tready;
      prev       = {o_tlast, o_terror, o_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Present one word from a falling edge until accepted.
  task automatic put(input logic [31:0] d, input logic l);
    logic rdy;
    int   guard = 0;
    i_tvalid = 1'b1; i_tdata = d; i_tlast = l;
    forever begin
      #1 rdy = i_tready;
      @(posedge clk);
      if (rdy) break;
      stalls++; guard++;
      if (guard > 2000) begin
        chk("put_timeout", 64'd0, 64'd1);
        $fatal(1, "input never accepted");
      end
      @(negedge clk);
    end
    @(negedge clk);
    i_tvalid = 1'b0; i_tlast = 1'b0;
    if (lat_chk) chk("latency", 64'({o_tvalid, o_tdata}), 64'({1'b1, d}));
  endtask

  // Send n words with header length len; queue the words expected out.
  task automatic send_pkt(input int pid, input int len, input int n, input bit drop_stall);
    int e, outn;
    bit bad;
    logic [31:0] d;
    bad  = (len == 0) || (len > MAXW);
    e    = bad ? MAXW : len;
    outn = (n < e) ? n : e;
    for (int i = 1; i <= n; i++) begin
      d = (i == 1) ? {pid[15:0], len[15:0]} : {pid[15:0], i[15:0]};
      if (i <= outn) ex_q.push_back({(i == outn), (i == outn) && (bad || n != e), d});
      if (drop_stall && i > outn) ordy_force = 1'b0;
      put(d, i == n);
    end
    ordy_force = 1'b1;
  endtask

  task automatic check_stream(input string tag);
    int k = 0;
    while (o_tvalid && k < 500) begin @(negedge clk); k++; end
    @(negedge clk);
    chk({tag, "_drain"}, 64'(o_tvalid), 64'd0);
    chk({tag, "_count"}, 64'(rx_q.size()), 64'(ex_q.size()));
    for (int i = 0; i < rx_q.size() && i < ex_q.size(); i++)
      chk({tag, "_word"}, 64'(rx_q[i]), 64'(ex_q[i]));
    rx_q.delete(); ex_q.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ovalid", 64'(o_tvalid), 64'd0);
    chk("rst_olast_err", 64'({o_tlast, o_terror}), 64'd0);
    chk("rst_odata", 64'(o_tdata), 64'd0);
    chk("rst_errcnt", 64'(err_cnt), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Good back-to-back packets, full throughput.
    lat_chk = 1'b1; stalls = 0;
    for (int p = 0; p < 4; p++) send_pkt(p, 16, 16, 1'b0);
    lat_chk = 1'b0;
    chk("good_stalls", 64'(stalls), 64'd0);
    check_stream("good");
    chk("good_errcnt", 64'(err_cnt), 64'd0);

    // Short packet, then a good one.
    send_pkt(10, 16, 10, 1'b0);
    send_pkt(11, 16, 16, 1'b0);
    check_stream("short");
    chk("short_errcnt", 64'(err_cnt), 64'd1);

    // Long packet truncated at 8; excess dropped while the output is stalled.
    stalls = 0;
    send_pkt(12, 8, 20, 1'b1);
    chk("drop_stalls", 64'(stalls), 64'd0);
    send_pkt(13, 5, 5, 1'b0);
    check_stream("long");
    chk("long_errcnt", 64'(err_cnt), 64'd2);

    // Bad headers: zero length and oversize length.
    send_pkt(14, 0, 4, 1'b0);
    send_pkt(15, 100, 70, 1'b0);
    check_stream("badhdr");
    chk("badhdr_errcnt", 64'(err_cnt), 64'd4);

    // Length-1 and length-MAX boundaries.
    send_pkt(16, 1, 1, 1'b0);
    send_pkt(17, 1, 3, 1'b0);
    send_pkt(18, 4, 1, 1'b0);
    send_pkt(19, 64, 64, 1'b0);
    send_pkt(20, 65, 64, 1'b0);
    check_stream("bound");
    chk("bound_errcnt", 64'(err_cnt), 64'd7);

    // Random output backpressure.
    bp_rand = 1'b1;
    for (int p = 0; p < 100; p++) send_pkt(100 + p, 16, 16, 1'b0);
    bp_rand = 1'b0;
    check_stream("bp");
    chk("bp_errcnt", 64'(err_cnt), 64'd7);

    // Asynchronous reset mid-body.
    put({16'h0300, 16'd16}, 1'b0);
    for (int i = 2; i <= 4; i++) put({16'h0300, 16'(i)}, 1'b0);
    mon_en = 1'b0;
    chk("pre_rst_valid", 64'(o_tvalid), 64'd1);
    #3 reset = 1'b1;
    #1;
    chk("arst_ovalid", 64'(o_tvalid), 64'd0);
    chk("arst_odata", 64'(o_tdata), 64'd0);
    chk("arst_errcnt", 64'(err_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    rx_q.delete(); ex_q.delete();
    mon_en = 1'b1;
    send_pkt(30, 4, 4, 1'b0);
    check_stream("after_rst");
    chk("after_rst_errcnt", 64'(err_cnt), 64'd0);

    // Synchronous clear mid-body.
    send_pkt(31, 16, 5, 1'b0);
    check_stream("pre_clr");
    chk("pre_clr_errcnt", 64'(err_cnt), 64'd1);
    put({16'h0320, 16'd16}, 1'b0);
    put({16'h0320, 16'd2}, 1'b0);
    mon_en = 1'b0;
    clear = 1'b1;
    #1 chk("clr_sync", 64'(o_tvalid), 64'd1);
    @(posedge clk); #1;
    chk("clr_outputs", 64'({o_tvalid, o_tlast, o_terror, o_tdata}), 64'd0);
    chk("clr_errcnt", 64'(err_cnt), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    rx_q.delete(); ex_q.delete();
    mon_en = 1'b1;
    send_pkt(32, 3, 3, 1'b0);
    check_stream("after_clr");
    chk("after_clr_errcnt", 64'(err_cnt), 64'd0);

    // Saturation: one-word packets with a zero-length header are each errored.
    rec = 1'b0;
    for (int k = 0; k < 65534; k++) put({16'hEEEE, 16'd0}, 1'b1);
    chk("sat_fffe", 64'(err_cnt), 64'hFFFE);
    for (int k = 0; k < 6; k++) put({16'hEEEE, 16'd0}, 1'b1);
    repeat (2) @(negedge clk);
    chk("sat_ffff", 64'(err_cnt), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
